// File: rtl/uart_receiver.sv
// uart_receiver
//   Receive side of the UART link. Deserialises 8N1 frames (start bit 0,
//   eight data bits with data[0] first on the wire, stop bit 1) and presents
//   each good byte with a one-cycle strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   uart_rx      serial line, asynchronous, idles high
//   data[0:7]    last good byte; data[0] is the first data bit received
//   data_valid   one-cycle pulse when data updates
//   frame_error  one-cycle pulse when the stop bit samples low
//   busy         high whenever the receiver is not idle
module uart_receiver #(
  parameter  int CLKS_PER_BIT = 1,
  localparam int HALF         = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [0:7] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  // Bit-period counter width; keep at least one bit for CLKS_PER_BIT == 1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [0:7]    shift, shift_nxt;
  logic [0:7]    data_nxt;
  logic          dv_nxt, fe_nxt;

  // Two-flop synchroniser. Both stages reset to the idle level so a reset
  // never looks like a start bit.
  logic sync1, rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  // State and output registers. busy is registered from the next state so it
  // tracks state exactly, without a cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= idx_nxt;
      shift       <= shift_nxt;
      data        <= data_nxt;
      data_valid  <= dv_nxt;
      frame_error <= fe_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = data;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;

    case (state)
      // The first low sample is cycle 0 of the start bit.
      IDLE: begin
        if (!rx_s) begin
          if (CLKS_PER_BIT == 1) begin
            // The whole start bit was that one cycle.
            state_nxt = DATA;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            state_nxt = START;
            cnt_nxt   = CW'(1);
          end
        end
      end

      // Confirm the start bit at mid-bit. With HALF == 0 cnt never equals
      // HALF here, because the IDLE sample already was the mid-bit sample.
      START: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == HALF_C && rx_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LAST_C) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end

      DATA: begin
        if (cnt == HALF_C)
          shift_nxt[bit_idx] = rx_s;
        if (cnt == LAST_C) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7)
            state_nxt = STOP;
          else
            idx_nxt = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      // Leave at mid-stop so the tail of the stop bit is spent in IDLE; a
      // start bit right behind the stop bit is then caught on its cycle 0.
      STOP: begin
        if (cnt == HALF_C) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (rx_s) begin
            data_nxt = shift;
            dv_nxt   = 1'b1;
          end else begin
            fe_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver. Three instances with CLKS_PER_BIT = 1, 4 and 8
// share clock and reset, and each one has its own serial line.
// The model predicts each frame's outcome from line timing: a frame whose
// start bit is driven after edge n completes at edge
// n + 3 + 9*CPB + HALF (2 synchroniser edges, 1 output register, and the
// mid-stop sample point).
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [0:7] dat [3];
  logic       dv  [3];
  logic       fe  [3];
  logic       bsy [3];

  int cpb_of [3] = '{1, 4, 8};

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst(rst), .uart_rx(rx[0]),
    .data(dat[0]), .data_valid(dv[0]), .frame_error(fe[0]), .busy(bsy[0]));
  uart_receiver #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst(rst), .uart_rx(rx[1]),
    .data(dat[1]), .data_valid(dv[1]), .frame_error(fe[1]), .busy(bsy[1]));
  uart_receiver #(.CLKS_PER_BIT(8)) u8 (
    .clk(clk), .rst(rst), .uart_rx(rx[2]),
    .data(dat[2]), .data_valid(dv[2]), .frame_error(fe[2]), .busy(bsy[2]));

  typedef struct {
    int         inst;
    int         at;
    bit         good;
    logic [0:7] d;
  } ev_t;

  ev_t        evq [$];
  logic [0:7] mdata [3];
  int         last_pulse [3];
  int         last_ferr  [3];
  int         plog [$];
  int         cyc      = 0;
  int         stop_cyc = 0;
  logic       rst_d    = 1'b1;
  bit         chk_en   = 1'b0;
  int         n_tests  = 0;
  int         n_fail   = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame on line i starting now. A low stop bit that outlasts the
  // mid-stop sample looks like a fresh start bit once the receiver is idle;
  // if it is still low at that start's mid-bit, the receiver takes a frame
  // of all ones from the idle line that follows. The caller must idle the
  // line high afterwards.
  task automatic send_frame(input int i, input logic [0:7] d, input bit stop);
    ev_t        e;
    logic [0:9] fr;
    int         c, h, n0;
    c  = cpb_of[i];
    h  = (c - 1) / 2;
    n0 = cyc;
    fr = {1'b0, d, stop};
    e.inst = i; e.at = n0 + 3 + 9*c + h; e.good = stop; e.d = d;
    evq.push_back(e);
    if (!stop && (2*h + 1 < c)) begin
      e.at = n0 + 9*c + h + 1 + 3 + 9*c + h; e.good = 1'b1; e.d = 8'hFF;
      evq.push_back(e);
    end
    stop_cyc = n0 + 9*c;
    for (int b = 0; b < 10; b++) begin
      rx[i] = fr[b];
      repeat (c) tick();
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin : cmp
    bit xv, xf;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        if (rst_d) begin
          mdata[i] = '0;
          chk($sformatf("u%0d.rst_data", cpb_of[i]), 32'(dat[i]), 0);
          chk($sformatf("u%0d.rst_valid", cpb_of[i]), 32'(dv[i]), 0);
          chk($sformatf("u%0d.rst_ferr", cpb_of[i]), 32'(fe[i]), 0);
          chk($sformatf("u%0d.rst_busy", cpb_of[i]), 32'(bsy[i]), 0);
        end else begin
          xv = 1'b0;
          xf = 1'b0;
          foreach (evq[k]) begin
            if (evq[k].inst == i && evq[k].at == cyc) begin
              if (evq[k].good) begin
                xv = 1'b1;
                mdata[i] = evq[k].d;
              end else begin
                xf = 1'b1;
              end
            end
          end
          chk($sformatf("u%0d.data_valid", cpb_of[i]), 32'(dv[i]), 32'(xv));
          chk($sformatf("u%0d.frame_error", cpb_of[i]), 32'(fe[i]), 32'(xf));
          chk($sformatf("u%0d.data", cpb_of[i]), 32'(dat[i]), 32'(mdata[i]));
          if (dv[i]) last_pulse[i] = cyc;
          if (fe[i]) last_ferr[i] = cyc;
          if (dv[i] && i == 0) plog.push_back(cyc);
        end
      end
      if (rst_d) evq.delete();
      else
        for (int k = evq.size() - 1; k >= 0; k--)
          if (evq[k].at <= cyc) evq.delete(k);
    end
  end

  initial begin
    // Reset then idle.
    rst = 1'b1;
    rx  = 3'b111;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (50) tick();
    for (int i = 0; i < 3; i++) begin
      chk("idle_busy", 32'(bsy[i]), 0);
      chk("idle_data", 32'(dat[i]), 0);
    end

    // Single frame, CPB=1: wire bits 0,1,0,1,1,0,0,1,0,1.
    send_frame(0, 8'b1011_0010, 1'b1);
    rx[0] = 1'b1;
    repeat (5) tick();
    chk("single_data", 32'(dat[0]), 32'hB2);
    chk("single_latency", 32'(last_pulse[0] - stop_cyc), 3);
    chk("single_busy_after", 32'(bsy[0]), 0);

    // Back-to-back at CPB=1, zero idle between frames.
    plog.delete();
    send_frame(0, 8'hA5, 1'b1);
    send_frame(0, 8'h3C, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    rx[0] = 1'b1;
    repeat (5) tick();
    chk("b2b_count", 32'(plog.size()), 3);
    if (plog.size() == 3) begin
      chk("b2b_gap0", 32'(plog[1] - plog[0]), 10);
      chk("b2b_gap1", 32'(plog[2] - plog[1]), 10);
    end
    chk("b2b_last_data", 32'(dat[0]), 32'hFF);

    // Framing error, CPB=4.
    send_frame(1, 8'h3C, 1'b1);
    send_frame(1, 8'h55, 1'b0);
    rx[1] = 1'b1;
    repeat (5) tick();
    chk("ferr_seen", 32'(last_ferr[1] - stop_cyc), 4);
    chk("ferr_data_held", 32'(dat[1]), 32'h3C);
    repeat (50) tick();
    send_frame(1, 8'h0F, 1'b1);
    rx[1] = 1'b1;
    repeat (10) tick();
    chk("ferr_next_data", 32'(dat[1]), 32'h0F);
    chk("ferr_busy_after", 32'(bsy[1]), 0);

    // Glitch / false start, CPB=8.
    rx[2] = 1'b0;
    repeat (2) tick();
    rx[2] = 1'b1;
    repeat (4) tick();
    chk("glitch_busy", 32'(bsy[2]), 0);
    repeat (20) tick();
    send_frame(2, 8'hC3, 1'b1);
    rx[2] = 1'b1;
    repeat (10) tick();
    chk("glitch_next_data", 32'(dat[2]), 32'hC3);

    // Reset mid-frame, CPB=1: start bit plus four data bits, then reset.
    rx[0] = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      rx[0] = 1'b1;
      tick();
    end
    chk("mid_busy", 32'(bsy[0]), 1);
    rst   = 1'b1;
    rx[0] = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_data", 32'(dat[0]), 0);
    chk("mid_rst_busy", 32'(bsy[0]), 0);
    repeat (15) tick();
    send_frame(0, 8'h81, 1'b1);
    rx[0] = 1'b1;
    repeat (5) tick();
    chk("mid_next_data", 32'(dat[0]), 32'h81);

    repeat (20) tick();
    chk("events_drained", 32'(evq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
